// File: rtl/dump_ch_engine.sv
// dump_ch_engine: streams one channel's circular capture buffer to the UART
// transmitter, oldest sample first, one byte per trmt/tx_done handshake.
// Optional build macro DUMP_CAL_EN adds a cal_offset port and applies a
// saturating signed calibration offset to every sample on its way out.
// DEPTH must equal 2**ADDR_W so that the read address wraps by overflow.
module dump_ch_engine #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start,
    input  logic [1:0]        ch_sel,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] rdata3,
    output logic [DATA_W-1:0] tx_data,
    output logic              trmt,
    input  logic              tx_done,
    output logic              busy,
    output logic              dump_done,
    output logic              dump_err
`ifdef DUMP_CAL_EN
    ,
    input  logic [DATA_W-1:0] cal_offset
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        ch;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] sample_out;
    logic              start_ok;
    logic              last_byte;

    assign start_ok  = dump_start && (ch_sel != 2'b11);
    assign last_byte = (cnt == CNT_LAST);

    // State register.
    // NOTE: sequential state is written with <= only, so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic for the dump sequence.
    // NOTE: state_nxt gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_READ;
            S_READ:    state_nxt = S_LATCH;
            S_LATCH:   state_nxt = S_SEND;
            S_SEND:    state_nxt = S_WAIT_TX;
            S_WAIT_TX: if (tx_done) state_nxt = last_byte ? S_DONE : S_READ;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so they are glitch-free
    // and drop to 0 on the same edge that reset forces IDLE.
    assign ram_rd_en = (state == S_READ);
    assign trmt      = (state == S_SEND);
    assign dump_done = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Select the sample of the latched channel.
    always_comb begin
        sample = rdata1;
        case (ch)
            2'b01:   sample = rdata2;
            2'b10:   sample = rdata3;
            default: sample = rdata1;
        endcase
    end

`ifdef DUMP_CAL_EN
    logic signed [DATA_W+1:0] cal_sum;

    // Add the signed offset with two guard bits, then clamp to 0..2**DATA_W-1:
    // the top bit flags a negative result, the next one an overflow.
    always_comb begin
        cal_sum = $signed({2'b00, sample}) +
                  $signed({{2{cal_offset[DATA_W-1]}}, cal_offset});
        if (cal_sum[DATA_W+1])   sample_out = '0;
        else if (cal_sum[DATA_W]) sample_out = '1;
        else                      sample_out = cal_sum[DATA_W-1:0];
    end
`else
    assign sample_out = sample;
`endif

    // Datapath registers: channel/address/count bookkeeping, read address,
    // transmit byte and the error pulse.
    // NOTE: every register here is a plain flop with a reset value; there is
    // no storage array in this block, so nothing is left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch       <= 2'b00;
            addr     <= '0;
            cnt      <= '0;
            ram_addr <= '0;
            tx_data  <= '0;
            dump_err <= 1'b0;
        end else begin
            dump_err <= (state == S_IDLE) && dump_start && (ch_sel == 2'b11);
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        ch       <= ch_sel;
                        addr     <= start_addr;
                        cnt      <= '0;
                        ram_addr <= start_addr;
                    end
                end
                S_LATCH: tx_data <= sample_out;
                S_WAIT_TX: begin
                    if (tx_done) begin
                        addr <= addr + ADDR_ONE;
                        cnt  <= cnt + CNT_ONE;
                        // Leave ram_addr on the final sample once the dump ends.
                        if (!last_byte) ram_addr <= addr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dump_ch_engine.sv
// Directed testbench for dump_ch_engine: behavioural capture RAMs, a UART
// responder with programmable tx_done latency and a byte/event monitor.
module tb_dump_ch_engine;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dump_start = 1'b0;
    logic [1:0]        ch_sel = 2'b00;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] rdata1 = '0;
    logic [DATA_W-1:0] rdata2 = '0;
    logic [DATA_W-1:0] rdata3 = '0;
    logic [DATA_W-1:0] tx_data;
    logic              trmt;
    logic              tx_done;
    logic              busy;
    logic              dump_done;
    logic              dump_err;
    logic              tx_done_resp = 1'b0;
    logic              tx_done_stray = 1'b0;
`ifdef DUMP_CAL_EN
    logic [DATA_W-1:0] cal_offset = '0;
`endif

    assign tx_done = tx_done_resp | tx_done_stray;

    dump_ch_engine #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dump_start (dump_start),
        .ch_sel     (ch_sel),
        .start_addr (start_addr),
        .ram_addr   (ram_addr),
        .ram_rd_en  (ram_rd_en),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .rdata3     (rdata3),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .busy       (busy),
        .dump_done  (dump_done),
        .dump_err   (dump_err)
`ifdef DUMP_CAL_EN
        ,
        .cal_offset (cal_offset)
`endif
    );

    always #5 clk = ~clk;

    // Capture RAM contents and synchronous read port.
    logic [7:0] mem1 [DEPTH];
    logic [7:0] mem2 [DEPTH];
    logic [7:0] mem3 [DEPTH];

    always @(posedge clk) begin
        if (ram_rd_en) begin
            rdata1 <= mem1[ram_addr];
            rdata2 <= mem2[ram_addr];
            rdata3 <= mem3[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART responder: tx_done arrives tx_lat clocks after each trmt.
    int tx_lat = 20;
    int resp_cnt = 0;
    always @(negedge clk) begin
        tx_done_resp = 1'b0;
        if (!busy) resp_cnt = 0;
        else if (trmt) resp_cnt = tx_lat;
        else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) tx_done_resp = 1'b1;
        end
    end

    // Monitor: log every transmitted byte and count events.
    logic [7:0] bytes[$];
    int         trmt_cyc[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         rd_cnt = 0;
    int         unstable = 0;
    logic       watching = 1'b0;
    logic [7:0] held = '0;
    always @(negedge clk) begin
        if (trmt) begin
            bytes.push_back(tx_data);
            trmt_cyc.push_back(cyc);
            held = tx_data;
            watching = 1'b1;
        end else if (!busy) begin
            watching = 1'b0;
        end else if (watching && tx_data !== held) begin
            unstable++;
        end
        if (dump_done) done_cnt++;
        if (dump_err)  err_cnt++;
        if (ram_rd_en) rd_cnt++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        if (idx < bytes.size()) return bytes[idx];
        return 8'hxx;
    endfunction

    function automatic int cyc_at(input int idx);
        if (idx < trmt_cyc.size()) return trmt_cyc[idx];
        return -1;
    endfunction

    function automatic logic [7:0] ram_val(input logic [1:0] ch, input int a);
        case (ch)
            2'b01:   return mem2[a];
            2'b10:   return mem3[a];
            default: return mem1[a];
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] s);
`ifdef DUMP_CAL_EN
        int v;
        v = int'(s) + int'($signed(cal_offset));
        if (v < 0)   return 8'h00;
        if (v > 255) return 8'hFF;
        return 8'(v);
`else
        return s;
`endif
    endfunction

    task automatic start_dump(input logic [1:0] ch, input logic [ADDR_W-1:0] sa, output int c0);
        @(negedge clk);
        dump_start = 1'b1;
        ch_sel     = ch;
        start_addr = sa;
        c0         = cyc;
        @(negedge clk);
        dump_start = 1'b0;
        // Scramble the inputs: the engine must have latched them already.
        ch_sel     = ch ^ 2'b01;
        start_addr = ~sa;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (dump_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " dump_done seen"}, 32'(ok), 1);
        if (ok) begin
            check({tag, " busy in done cycle"}, 32'(busy), 1);
            @(negedge clk);
            check({tag, " busy after done"}, 32'(busy), 0);
            check({tag, " dump_done one cycle"}, 32'(dump_done), 0);
        end
    endtask

    task automatic cmp_dump(input string tag, input int base, input logic [1:0] ch,
                            input logic [ADDR_W-1:0] sa);
        int errs;
        errs = 0;
        check({tag, " byte count"}, 32'(bytes.size() - base), DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            if (byte_at(base + k) !== exp_byte(ram_val(ch, (int'(sa) + k) % DEPTH))) errs++;
        end
        check({tag, " byte order"}, 32'(errs), 0);
    endtask

    initial begin
        int base;
        int d0;
        int e0;
        int r0;
        int c0;
        int k;
        logic ok;

        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = 8'(i * 37 + (i >> 8) * 91 + 11);
            mem3[i] = 8'(255 - i + (i >> 8) * 77);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 0);
        check("reset trmt", 32'(trmt), 0);
        check("reset ram_rd_en", 32'(ram_rd_en), 0);
        check("reset tx_data", 32'(tx_data), 0);
        check("reset ram_addr", 32'(ram_addr), 0);
        check("reset dump_done", 32'(dump_done), 0);
        rst_n = 1'b1;

        // Channel 1 from address 0 with 20-clock UART latency.
        base = bytes.size();
        d0   = done_cnt;
        start_dump(2'b00, 9'h000, c0);
        check("t1 busy after start", 32'(busy), 1);
        wait_done("t1");
        cmp_dump("t1", base, 2'b00, 9'h000);
        check("t1 first trmt latency", 32'(cyc_at(base) - c0), 3);
        check("t1 inter-byte gap", 32'(cyc_at(base + 1) - cyc_at(base)), 23);
        check("t1 byte 255", 32'(byte_at(base + 255)), 32'h0000_00FF);
        check("t1 byte 256", 32'(byte_at(base + 256)), 32'h0000_0000);
        check("t1 byte 511", 32'(byte_at(base + 511)), 32'h0000_00FF);
        check("t1 done count", 32'(done_cnt - d0), 1);
        check("t1 ram_addr holds", 32'(ram_addr), 32'h1FF);
        check("t1 tx_data stable", 32'(unstable), 0);

        // Channel 2 from 0x134, wrapping through 0x1FF -> 0x000.
        tx_lat = 4;
        base = bytes.size();
        start_dump(2'b01, 9'h134, c0);
        wait_done("t2");
        cmp_dump("t2", base, 2'b01, 9'h134);
        check("t2 byte 0", 32'(byte_at(base)), 32'(mem2[9'h134]));
        check("t2 byte 203", 32'(byte_at(base + 203)), 32'(mem2[9'h1FF]));
        check("t2 byte 204", 32'(byte_at(base + 204)), 32'(mem2[9'h000]));
        check("t2 byte 511", 32'(byte_at(base + 511)), 32'(mem2[9'h133]));

        // Invalid channel select.
        e0 = err_cnt;
        r0 = rd_cnt;
        base = bytes.size();
        @(negedge clk);
        dump_start = 1'b1;
        ch_sel     = 2'b11;
        start_addr = 9'h005;
        @(negedge clk);
        dump_start = 1'b0;
        check("t3 dump_err pulse", 32'(dump_err), 1);
        check("t3 busy stays low", 32'(busy), 0);
        @(negedge clk);
        check("t3 dump_err one cycle", 32'(dump_err), 0);
        repeat (5) @(negedge clk);
        check("t3 err count", 32'(err_cnt - e0), 1);
        check("t3 no ram reads", 32'(rd_cnt - r0), 0);
        check("t3 no trmt", 32'(bytes.size() - base), 0);

        // Stray tx_done and repeated dump_start must be ignored.
        e0   = err_cnt;
        d0   = done_cnt;
        base = bytes.size();
        @(negedge clk);
        tx_done_stray = 1'b1;
        @(negedge clk);
        tx_done_stray = 1'b0;
        check("t4 idle tx_done ignored", 32'(busy), 0);
        start_dump(2'b00, 9'h0FF, c0);
        for (int n = 0; n < 3; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (ram_rd_en) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("t4 READ reached", 32'(ok), 1);
            tx_done_stray = 1'b1;
            dump_start    = 1'b1;
            ch_sel        = (n == 1) ? 2'b11 : 2'b01;
            start_addr    = 9'h000;
            @(negedge clk);
            tx_done_stray = 1'b0;
            dump_start    = 1'b0;
            repeat (30) @(negedge clk);
        end
        wait_done("t4");
        cmp_dump("t4", base, 2'b00, 9'h0FF);
        check("t4 done count", 32'(done_cnt - d0), 1);
        check("t4 no dump_err", 32'(err_cnt - e0), 0);

        // Reset one clock after byte 100's trmt aborts the dump.
        d0   = done_cnt;
        base = bytes.size();
        start_dump(2'b01, 9'h010, c0);
        k = 0;
        for (int i = 0; i < 5000; i++) begin
            if (trmt) k++;
            if (k == 100) break;
            @(negedge clk);
        end
        check("t5 reached byte 100", 32'(k), 100);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5 rst busy", 32'(busy), 0);
        check("t5 rst trmt", 32'(trmt), 0);
        check("t5 rst ram_rd_en", 32'(ram_rd_en), 0);
        check("t5 rst tx_data", 32'(tx_data), 0);
        check("t5 rst ram_addr", 32'(ram_addr), 0);
        check("t5 rst dump_done", 32'(dump_done), 0);
        repeat (60) @(negedge clk);
        check("t5 bytes before abort", 32'(bytes.size() - base), 100);
        check("t5 byte 99", 32'(byte_at(base + 99)), 32'(mem2[9'h010 + 9'd99]));
        check("t5 no dump_done", 32'(done_cnt - d0), 0);

        // A fresh dump after the abort, channel 3 from 0x1F0.
        d0   = done_cnt;
        base = bytes.size();
        start_dump(2'b10, 9'h1F0, c0);
        wait_done("t6");
        cmp_dump("t6", base, 2'b10, 9'h1F0);
        check("t6 first trmt latency", 32'(cyc_at(base) - c0), 3);
        check("t6 done count", 32'(done_cnt - d0), 1);
        check("t6 tx_data stable", 32'(unstable), 0);

`ifdef DUMP_CAL_EN
        // Calibration offset -16, then +32, on the ramp of channel 1.
        cal_offset = 8'hF0;
        base = bytes.size();
        start_dump(2'b00, 9'h000, c0);
        wait_done("t7");
        cmp_dump("t7", base, 2'b00, 9'h000);
        check("t7 0x05 clamps low", 32'(byte_at(base + 5)), 32'h00);
        check("t7 0x80 minus 16", 32'(byte_at(base + 128)), 32'h70);
        cal_offset = 8'h20;
        base = bytes.size();
        start_dump(2'b00, 9'h000, c0);
        wait_done("t8");
        cmp_dump("t8", base, 2'b00, 9'h000);
        check("t8 0xF0 clamps high", 32'(byte_at(base + 240)), 32'hFF);
        check("t8 0x10 plus 32", 32'(byte_at(base + 16)), 32'h30);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
